// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
// Holds the FSM state encoding and the counter-width helper.
package bit_serializer_pkg;

    localparam int SER_DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Width needed to index 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel word input handshake of the bit serializer.
// A word moves on a rising edge where in_valid and in_ready are both 1; the source
// keeps in_data stable and in_valid high until then, and in_ready never looks at in_valid.
interface bit_serializer_if
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/bit_serializer_hold.sv
// Single-entry holding buffer that lets the next word wait behind the one being shifted.
// Owns the ready signal back to the word source.
module bit_serializer_hold
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             ready_o
);

    logic [WIDTH-1:0] hreg_q;
    logic [WIDTH-1:0] hreg_d;
    logic             full_q;
    logic             full_d;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            hreg_q <= '0;
            full_q <= 1'b0;
        end else begin
            hreg_q <= hreg_d;
            full_q <= full_d;
        end
    end

    // Load and drain are mutually exclusive: a full buffer holds ready low.
    always_comb begin
        hreg_d = hreg_q;
        full_d = full_q;
        if (load_i) begin
            hreg_d = data_i;
            full_d = 1'b1;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    // rst_n is active high despite its name.
    assign ready_o = !full_q && !rst_n;
    assign data_o  = hreg_q;
    assign full_o  = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: shifts WIDTH-bit words out one bit per clock with a
// bit-valid qualifier, streaming back-to-back words through a one-word holding buffer.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int   WIDTH     = SER_DEFAULT_WIDTH,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    bit_serializer_if.slave   in_if,
    output logic              bit_o,
    output logic              bit_valid_o,
    output logic              word_done_o,
    output logic              busy_o,
    output ser_state_e        state_o
);

    localparam int             CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_e       state_q;
    ser_state_e       state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             xfer;
    logic             last_bit;
    logic             hold_load;
    logic             hold_drain;
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic [WIDTH-1:0] sreg_shifted;
    logic             out_end;

    assign xfer     = in_if.in_valid && in_if.in_ready;
    assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // A word arriving mid-shift parks in the buffer; on the last bit it bypasses it.
    assign hold_load  = xfer && (state_q == SHIFT) && !last_bit;
    assign hold_drain = last_bit && hold_full;

    bit_serializer_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (hold_load),
        .drain_i (hold_drain),
        .data_i  (in_if.in_data),
        .data_o  (hold_data),
        .full_o  (hold_full),
        .ready_o (in_if.in_ready)
    );

    assign sreg_shifted = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0}
                                           : {1'b0, sreg_q[WIDTH-1:1]};
    assign out_end      = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    sreg_d  = in_if.in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    sreg_d = sreg_shifted;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else if (hold_full) begin
                    sreg_d = hold_data;
                    cnt_d  = '0;
                end else if (xfer) begin
                    sreg_d = in_if.in_data;
                    cnt_d  = '0;
                end else begin
                    sreg_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bit_valid_o = (state_q == SHIFT);
    assign bit_o       = bit_valid_o ? out_end : IDLE_BIT;
    assign word_done_o = last_bit;
    assign busy_o      = (state_q == SHIFT) || hold_full;
    assign state_o     = state_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an 8-bit MSB-first instance and a 5-bit
// LSB-first instance with a high idle level, checked against hand-computed bit streams.
module tb_bit_serializer;
    import bit_serializer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(8)) if8 ();
    bit_serializer_if #(.WIDTH(5)) if5 ();

    logic       b8_bit, b8_bv, b8_wd, b8_busy;
    ser_state_e b8_state;
    logic       b5_bit, b5_bv, b5_wd, b5_busy;
    ser_state_e b5_state;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_if       (if8),
        .bit_o       (b8_bit),
        .bit_valid_o (b8_bv),
        .word_done_o (b8_wd),
        .busy_o      (b8_busy),
        .state_o     (b8_state)
    );

    bit_serializer #(.WIDTH(5), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_if       (if5),
        .bit_o       (b5_bit),
        .bit_valid_o (b5_bv),
        .word_done_o (b5_wd),
        .busy_o      (b5_busy),
        .state_o     (b5_state)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;
    int fail_cnt  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        check_cnt = check_cnt + 1;
        assert (obs === exp_v) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    logic [7:0]  w8;
    logic [15:0] w16;
    logic [23:0] w24;
    logic [9:0]  w10;

    initial begin
        rst_n        = 1'b1;
        if8.in_valid = 1'b0;
        if8.in_data  = '0;
        if5.in_valid = 1'b0;
        if5.in_data  = '0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready8", if8.in_ready, 1'b0);
            chk("rst_bv8", b8_bv, 1'b0);
            chk("rst_bit8", b8_bit, 1'b0);
            chk("rst_busy8", b8_busy, 1'b0);
            chk("rst_wd8", b8_wd, 1'b0);
            chk("rst_ready5", if5.in_ready, 1'b0);
            chk("rst_bit5", b5_bit, 1'b1);
        end
        rst_n = 1'b0;
        step();
        chk("idle_ready8", if8.in_ready, 1'b1);
        chk("idle_bv8", b8_bv, 1'b0);
        chk("idle_busy8", b8_busy, 1'b0);
        chk("idle_bit8", b8_bit, 1'b0);
        chk("idle_state8", b8_state == IDLE, 1'b1);
        chk("idle_ready5", if5.in_ready, 1'b1);
        chk("idle_bit5", b5_bit, 1'b1);

        // Single word 8'h11
        w8 = 8'h11;
        if8.in_data  = w8;
        if8.in_valid = 1'b1;
        step();
        if8.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("single_bit", b8_bit, w8[7-i]);
            chk("single_bv", b8_bv, 1'b1);
            chk("single_wd", b8_wd, i == 7);
            chk("single_busy", b8_busy, 1'b1);
            step();
        end
        chk("single_end_bv", b8_bv, 1'b0);
        chk("single_end_wd", b8_wd, 1'b0);
        chk("single_end_busy", b8_busy, 1'b0);
        chk("single_end_bit", b8_bit, 1'b0);

        // Back-to-back 8'h88, 8'h80 through the holding buffer
        w16 = 16'h8880;
        if8.in_data  = 8'h88;
        if8.in_valid = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            chk("b2b_bit", b8_bit, w16[15-i]);
            chk("b2b_bv", b8_bv, 1'b1);
            chk("b2b_wd", b8_wd, (i % 8) == 7);
            if (i == 0 || i == 8) chk("b2b_ready_hi", if8.in_ready, 1'b1);
            if (i >= 1 && i <= 7) chk("b2b_ready_lo", if8.in_ready, 1'b0);
            if (i == 0) if8.in_data = 8'h80;
            if (i == 1) if8.in_valid = 1'b0;
            step();
        end
        chk("b2b_end_bv", b8_bv, 1'b0);
        chk("b2b_end_busy", b8_busy, 1'b0);

        // Backpressure: third word stalls until the buffer drains
        w24 = 24'hC35A96;
        if8.in_data  = 8'hC3;
        if8.in_valid = 1'b1;
        step();
        for (int i = 0; i < 24; i++) begin
            chk("bp_bit", b8_bit, w24[23-i]);
            chk("bp_bv", b8_bv, 1'b1);
            chk("bp_wd", b8_wd, (i % 8) == 7);
            chk("bp_ready", if8.in_ready, (i == 0) || (i == 8) || (i >= 16));
            if (i == 0) if8.in_data = 8'h5A;
            if (i == 1) if8.in_data = 8'h96;
            if (i == 9) if8.in_valid = 1'b0;
            step();
        end
        chk("bp_end_bv", b8_bv, 1'b0);
        chk("bp_end_busy", b8_busy, 1'b0);

        // Reset at bit 4 of 8'hA5 with the buffer full
        w8 = 8'hA5;
        if8.in_data  = w8;
        if8.in_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("mid_bit", b8_bit, w8[7-i]);
            if (i >= 1) chk("mid_busy", b8_busy, 1'b1);
            if (i == 0) if8.in_data = 8'hFF;
            if (i == 1) if8.in_valid = 1'b0;
            if (i == 4) rst_n = 1'b1;
            if (i < 4) step();
        end
        chk("mid_ready_in_rst", if8.in_ready, 1'b0);
        step();
        chk("mid_rst_bv", b8_bv, 1'b0);
        chk("mid_rst_busy", b8_busy, 1'b0);
        chk("mid_rst_bit", b8_bit, 1'b0);
        chk("mid_rst_ready", if8.in_ready, 1'b0);
        chk("mid_rst_state", b8_state == IDLE, 1'b1);
        rst_n = 1'b0;
        step();
        chk("mid_rel_ready", if8.in_ready, 1'b1);
        chk("mid_rel_bv", b8_bv, 1'b0);
        chk("mid_rel_busy", b8_busy, 1'b0);
        w8 = 8'h01;
        if8.in_data  = w8;
        if8.in_valid = 1'b1;
        step();
        if8.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("post_bit", b8_bit, w8[7-i]);
            chk("post_bv", b8_bv, 1'b1);
            chk("post_wd", b8_wd, i == 7);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            chk("post_idle_bv", b8_bv, 1'b0);
            chk("post_idle_busy", b8_busy, 1'b0);
            step();
        end

        // WIDTH=5 LSB-first, second word loaded directly on the last-bit edge
        w10 = 10'b10001_01100;
        if5.in_data  = 5'b10001;
        if5.in_valid = 1'b1;
        step();
        if5.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("lsb_bit", b5_bit, w10[9-i]);
            chk("lsb_bv", b5_bv, 1'b1);
            chk("lsb_wd", b5_wd, (i == 4) || (i == 9));
            chk("lsb_busy", b5_busy, 1'b1);
            if (i == 4) begin
                chk("lsb_ready_last", if5.in_ready, 1'b1);
                if5.in_data  = 5'b00110;
                if5.in_valid = 1'b1;
            end
            if (i == 5) if5.in_valid = 1'b0;
            step();
        end
        chk("lsb_end_bv", b5_bv, 1'b0);
        chk("lsb_end_bit", b5_bit, 1'b1);
        chk("lsb_end_busy", b5_busy, 1'b0);
        chk("lsb_end_state", b5_state == IDLE, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end for the serial sequence-detector stage.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, together with a bit-valid qualifier.
- A one-word holding buffer allows back-to-back words to stream with no idle cycles.
- Output `bit` connects directly to the detector's serial input `bit`.

Parameters:
- WIDTH, 8: bits per input word, minimum 2.
- MSB_FIRST, 1: 1 means in_data[WIDTH-1] is sent first; 0 means in_data[0] is sent first.
- IDLE_BIT, 0: level driven on `bit` when no word is being shifted.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-high reset: a 1 sampled on the rising edge of clk resets the block. The name is the codebase's; the polarity is high.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- bit  output  1  serial data, registered.
- bit_valid  output  1  `bit` carries payload this cycle, registered.
- word_done  output  1  one-cycle pulse coincident with the last bit of a word.
- busy  output  1  shift register or holding buffer is occupied.

Behaviour:
- Handshake:
  - A word transfers on a rising edge where in_valid and in_ready are both 1.
  - in_ready = !hold_full && !rst_n. It is combinational from registered state only, with no path from in_valid.
  - in_data must be held stable while in_valid=1 and in_ready=0. The source must not retract a pending word.
- Storage: shift register sreg[WIDTH-1:0], bit counter cnt (clog2(WIDTH) bits), holding register hreg, flag hold_full.
- States:
  - IDLE: sreg empty.
  - SHIFT: a word is being shifted; cnt = index of the bit currently on `bit`.
- IDLE transitions:
  - On a transfer, load sreg directly (bypassing hreg), set cnt=0, go to SHIFT.
  - The first bit appears on `bit` in the cycle after the transfer edge (latency 1).
- SHIFT, each edge:
  - Shift sreg toward the output end: left if MSB_FIRST, right otherwise.
  - cnt increments by 1.
- SHIFT, last bit (cnt==WIDTH-1):
  - word_done=1 in that same cycle.
  - On the next edge, if hold_full: move hreg into sreg, clear hold_full, cnt=0, stay in SHIFT. This gives a contiguous stream.
  - Else, if a transfer occurs on that edge: load in_data directly into sreg, cnt=0, stay in SHIFT.
  - Else: go to IDLE.
- SHIFT, transfer arriving while not on the last bit: word goes to hreg, hold_full=1.
- Simultaneous events: hold_full=1 forces in_ready=0, so hreg drain and a new accept never coincide.
- Output drive:
  - `bit` = output end of sreg when bit_valid=1, else IDLE_BIT.
  - bit_valid=1 exactly when the state is SHIFT.
  - busy = (state==SHIFT) || hold_full.
- Reset values (rst_n=1 sampled):
  - bit=IDLE_BIT, bit_valid=0, word_done=0, busy=0, in_ready=0 while reset is asserted, cnt=0, hold_full=0, state=IDLE.
  - Reset mid-word discards sreg and hreg contents immediately. No partial word resumes.
  - in_ready returns to 1 in the first cycle with rst_n=0.
- Throughput: 1 bit per clock sustained; 1 word per WIDTH clocks with zero gap when the source keeps hreg filled.
- Width rule: cnt wraps only through explicit reload to 0, never by overflow. Non-power-of-2 WIDTH must work.

Decomposition:
- Shared package bit_serializer_pkg holds:
  - state enum {IDLE, SHIFT}, 1-bit encoding;
  - function clog2 for cnt width;
  - constant SER_DEFAULT_WIDTH=8.
- One natural sub-module, bit_serializer_hold: single-entry holding buffer with load/drain/full. It contains hreg, hold_full and the in_ready generation.
- The top level keeps the FSM, sreg and cnt.

Test Plan:
- Reset, idle: assert rst_n 3 cycles, then release with in_valid=0 -> in_ready=0 during reset, then 1; bit_valid=0; bit=IDLE_BIT; busy=0.
- Single word, WIDTH=8, MSB_FIRST=1: send 8'h11 -> bit sequence 0,0,0,1,0,0,0,1 on 8 consecutive cycles starting 1 cycle after the transfer; word_done only on the 8th bit; bit_valid=1 for exactly 8 cycles.
- Back-to-back: 8'h88 then 8'h80 with in_valid held high -> 16 contiguous valid bits 1000_1000_1000_0000; no bit_valid gap; in_ready=0 from accept of word 2 until the edge after word 1's last bit.
- Backpressure: 3 words offered continuously -> word 3 stalls (in_ready=0) until hreg drains; all 24 bits emerge in order; in_data of word 3 is not corrupted.
- Reset mid-word: assert rst_n at bit 4 of 8'hA5 with hreg full -> next cycle bit_valid=0, busy=0; after release, new word 8'h01 emits 0000_0001 only.
- LSB-first, WIDTH=5, MSB_FIRST=0: send 5'b10001 -> bits 1,0,0,0,1; word_done on the 5th; verifies non-power-of-2 cnt.
